report_collector: RTL and testbench

Downstream stage of the STE automaton array. Each cycle a character is consumed, it samples the array's reporting-STE vector. Whenever any bit is set, it tags the vector with the 0-based stream offset of that character and pushes the record into an internal FIFO. Records drain to the host side over a valid/ready interface. Overflow is recorded, never silently lost.

---
 rtl/report_collector_if.sv | 23 ++
 rtl/report_collector.sv | 109 ++++++++++
 tb/tb_report_collector.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/report_collector_if.sv
// Match-report stream between the STE array, the report collector and the host.
// slave is the collector's view; master is the view of whoever drives characters and drains records.
interface report_collector_if #(
    parameter int REPORT_WIDTH = 2,
    parameter int OFFSET_WIDTH = 32
);
    logic                    char_valid;
    logic [REPORT_WIDTH-1:0] report;
    logic                    out_valid;
    logic                    out_ready;
    logic [OFFSET_WIDTH-1:0] out_offset;
    logic [REPORT_WIDTH-1:0] out_vector;

    modport master (
        output char_valid, report, out_ready,
        input  out_valid, out_offset, out_vector
    );

    modport slave (
        input  char_valid, report, out_ready,
        output out_valid, out_offset, out_vector
    );
endinterface

// File: rtl/report_collector.sv
// Tags non-zero reporting-STE vectors with their character offset and queues them for the host.
// The head record lives in the output registers; the memory holds only the records behind it.
module report_collector #(
    parameter int REPORT_WIDTH = 2,
    parameter int OFFSET_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    report_collector_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0] occupancy,
    output logic                        overflow,
    output logic [15:0]                 dropped_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = OFFSET_WIDTH + REPORT_WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [RW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_reg;
    logic [AW-1:0]           rd_ptr_reg;
    logic [AW:0]             occ_reg;
    logic [OFFSET_WIDTH-1:0] offset_reg;
    logic                    out_valid_reg;
    logic [RW-1:0]           head_reg;
    logic                    overflow_reg;
    logic [15:0]             dropped_reg;

    logic          push_req;
    logic          pop;
    logic          full;
    logic          mem_empty;
    logic          push_acc;
    logic          head_load;
    logic          mem_read;
    logic          bypass;
    logic          mem_write;
    logic [RW-1:0] wr_data;

    always_comb begin
        push_req  = bus.char_valid && (|bus.report);
        pop       = out_valid_reg && bus.out_ready;
        full      = (occ_reg == FULL_COUNT);
        // Records behind the head: occupancy minus the one sitting in the output registers.
        mem_empty = (occ_reg == {{AW{1'b0}}, out_valid_reg});
        push_acc  = push_req && (!full || pop);
        head_load = pop || !out_valid_reg;
        mem_read  = head_load && !mem_empty;
        bypass    = head_load && mem_empty && push_acc;
        mem_write = push_acc && !bypass;
        wr_data   = {offset_reg, bus.report};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            offset_reg    <= '0;
            out_valid_reg <= 1'b0;
            head_reg      <= '0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= '0;
        end else if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            offset_reg    <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= '0;
        end else begin
            if (bus.char_valid)
                offset_reg <= offset_reg + 1'b1;
            if (mem_write)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (mem_read) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                head_reg      <= mem[rd_ptr_reg];
                out_valid_reg <= 1'b1;
            end else if (bypass) begin
                head_reg      <= wr_data;
                out_valid_reg <= 1'b1;
            end else if (head_load) begin
                out_valid_reg <= 1'b0;
            end
            occ_reg <= occ_reg + (AW + 1)'(push_acc) - (AW + 1)'(pop);
            if (push_req && full && !pop) begin
                overflow_reg <= 1'b1;
                if (dropped_reg != 16'hFFFF)
                    dropped_reg <= dropped_reg + 1'b1;
            end
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (reset_n && !clear && mem_write)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_offset = head_reg[RW-1:REPORT_WIDTH];
    assign bus.out_vector = head_reg[REPORT_WIDTH-1:0];
    assign occupancy      = occ_reg;
    assign overflow       = overflow_reg;
    assign dropped_count  = dropped_reg;
endmodule

// File: tb/tb_report_collector.sv
// Randomized and directed bench for report_collector against a queue-based model.
module tb_report_collector;
    localparam int RW = 2;
    localparam int OW = 4;
    localparam int D  = 16;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear   = 1'b0;
    logic [4:0]  occupancy;
    logic        overflow;
    logic [15:0] dropped_count;

    report_collector_if #(.REPORT_WIDTH(RW), .OFFSET_WIDTH(OW)) bus ();

    report_collector #(
        .REPORT_WIDTH(RW),
        .OFFSET_WIDTH(OW),
        .FIFO_DEPTH  (D)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .bus          (bus),
        .occupancy    (occupancy),
        .overflow     (overflow),
        .dropped_count(dropped_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned off;
        int unsigned vec;
    } rec_t;

    rec_t        model_q[$];
    int unsigned model_cnt  = 0;
    bit          model_ovf  = 0;
    int unsigned model_drop = 0;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp)
            checks_passed++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic compare_outputs();
        check_value("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check_value("out_offset", 32'(bus.out_offset), model_q[0].off);
            check_value("out_vector", 32'(bus.out_vector), model_q[0].vec);
        end
        check_value("occupancy", 32'(occupancy), 32'(model_q.size()));
        check_value("overflow", 32'(overflow), 32'(model_ovf));
        check_value("dropped_count", 32'(dropped_count), model_drop);
    endtask

    task automatic model_step(input logic cv, input logic [1:0] rep, input logic rdy, input logic clr);
        rec_t r;
        if (clr) begin
            model_q.delete();
            model_cnt  = 0;
            model_ovf  = 0;
            model_drop = 0;
            $display("clear");
            return;
        end
        if (rdy && model_q.size() > 0) begin
            r = model_q.pop_front();
            $display("pop    offset=%0d vector=%b", r.off, r.vec[1:0]);
        end
        if (cv && rep != 2'b00) begin
            if (model_q.size() < D) begin
                r.off = model_cnt;
                r.vec = 32'(rep);
                model_q.push_back(r);
            end else begin
                model_ovf = 1;
                if (model_drop != 16'hFFFF)
                    model_drop++;
                $display("drop   offset=%0d vector=%b", model_cnt, rep);
            end
        end
        if (cv)
            model_cnt = (model_cnt + 1) % (1 << OW);
    endtask

    // Called one time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic cycle(input logic cv, input logic [1:0] rep, input logic rdy, input logic clr);
        bus.char_valid = cv;
        bus.report     = rep;
        bus.out_ready  = rdy;
        clear          = clr;
        compare_outputs();
        model_step(cv, rep, rdy, clr);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.char_valid = 1'b0;
        bus.report     = '0;
        bus.out_ready  = 1'b0;
        clear          = 1'b0;
        #1;
        model_q.delete();
        model_cnt  = 0;
        model_ovf  = 0;
        model_drop = 0;
        check_value("rst_out_offset", 32'(bus.out_offset), 32'd0);
        check_value("rst_out_vector", 32'(bus.out_vector), 32'd0);
        compare_outputs();
        $display("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [1:0] nz_report();
        return 2'($urandom_range(1, 3));
    endfunction

    initial begin
        #1;
        do_reset();

        // Basic tagging: records at offsets 2 and 4.
        cycle(1, 2'b00, 1, 0);
        cycle(1, 2'b00, 1, 0);
        cycle(1, 2'b01, 1, 0);
        cycle(1, 2'b00, 1, 0);
        cycle(1, 2'b11, 1, 0);
        cycle(0, 2'b00, 1, 0);
        cycle(0, 2'b00, 1, 0);

        // Backpressure then drain in order.
        do_reset();
        for (int i = 0; i < D; i++) cycle(1, nz_report(), 0, 0);
        check_value("bp_full_occ", 32'(occupancy), 32'd16);
        for (int i = 0; i < D; i++) cycle(0, 2'b00, 1, 0);
        check_value("bp_drained_valid", 32'(bus.out_valid), 32'd0);

        // Overflow: three drops while full.
        for (int i = 0; i < D; i++) cycle(1, nz_report(), 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, nz_report(), 0, 0);
        check_value("ovf_flag", 32'(overflow), 32'd1);
        check_value("ovf_dropped", 32'(dropped_count), 32'd3);
        check_value("ovf_occ", 32'(occupancy), 32'd16);

        // Full with simultaneous push and pop, then drain.
        do_reset();
        for (int i = 0; i < D; i++) cycle(1, nz_report(), 0, 0);
        cycle(1, 2'b10, 1, 0);
        check_value("fullpp_occ", 32'(occupancy), 32'd16);
        check_value("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < D + 1; i++) cycle(0, 2'b00, 1, 0);

        // Offset wrap, then clear colliding with a push.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 2'b00, 0, 0);
        cycle(1, 2'b01, 0, 0);
        check_value("wrap_offset", 32'(bus.out_offset), 32'd0);
        check_value("wrap_ovf", 32'(overflow), 32'd0);
        cycle(1, 2'b11, 0, 0);
        cycle(1, 2'b10, 0, 1);
        check_value("clr_valid", 32'(bus.out_valid), 32'd0);
        check_value("clr_occ", 32'(occupancy), 32'd0);
        cycle(1, 2'b01, 0, 0);
        check_value("clr_next_offset", 32'(bus.out_offset), 32'd0);
        cycle(0, 2'b00, 1, 0);

        // Asynchronous reset mid-cycle with five records held.
        for (int i = 0; i < 5; i++) cycle(1, nz_report(), 0, 0);
        check_value("arst_pre_occ", 32'(occupancy), 32'd5);
        #2;
        do_reset();

        // Random traffic with varying consumer pressure.
        for (int seg = 0; seg < 6; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 3 == 0) ? 100 : (seg % 3 == 1) ? 50 : 15;
            for (int i = 0; i < 300; i++) begin
                logic       cv;
                logic [1:0] rep;
                logic       rdy;
                logic       clr;
                cv  = ($urandom_range(0, 99) < 80);
                rep = 2'($urandom_range(0, 3));
                rdy = ($urandom_range(0, 99) < rdy_pct);
                clr = ($urandom_range(0, 199) == 0);
                cycle(cv, rep, rdy, clr);
            end
        end
        for (int i = 0; i < D + 2; i++) cycle(0, 2'b00, 1, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
